// File: rtl/dbg_panel_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : dbg_panel_ctrl                                              |
// | Purpose  : Debug-panel controller: switch debounce and select decode,  |
// |            clock-monitor count qualification, debug LED pattern mux.   |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module dbg_panel_ctrl #(
  parameter int unsigned DEB_CYCLES = 250_000,
  parameter int unsigned HB_MSB     = 24,
  parameter logic [31:0] CNT0_MIN   = 32'd1_248_750,
  parameter logic [31:0] CNT0_MAX   = 32'd1_251_250,
  parameter logic [31:0] CNT1_MIN   = 32'd1_483_515,
  parameter logic [31:0] CNT1_MAX   = 32'd1_486_485
) (
  input  logic        clk_25m,
  input  logic        rst_in,
  input  logic [3:0]  sw_n_i,
  input  logic [31:0] mon_cnt0_i,
  input  logic [31:0] mon_cnt1_i,
  input  logic        mon_vld_i,
  input  logic        clr_fault_i,
  output logic [2:0]  sel_o,
  output logic [1:0]  clk_ok_o,
  output logic [1:0]  clk_fault_o,
  output logic [3:0]  led_o
);

  localparam int unsigned      DEB_W    = $clog2(DEB_CYCLES);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam int unsigned      HB_W     = HB_MSB + 1;

  logic [3:0]      sw_meta_q;
  logic [3:0]      sw_sync_q;
  logic [3:0]      stable_w;
  logic [2:0]      sel_q, sel_d;
  logic [HB_W-1:0] hb_q;
  logic [3:0]      led_q, led_d;

  // Two-flop synchronizer on the raw switch pins; released (1) out of reset.
  always_ff @(posedge clk_25m or posedge rst_in) begin
    if (rst_in) begin
      sw_meta_q <= 4'hF;
      sw_sync_q <= 4'hF;
    end else begin
      sw_meta_q <= sw_n_i;
      sw_sync_q <= sw_meta_q;
    end
  end

  generate
    for (genvar i = 0; i < 4; i++) begin : g_deb
      logic             stab_q, stab_d;
      logic [DEB_W-1:0] cnt_q, cnt_d;

      // Accept a new level only after it has differed for DEB_CYCLES cycles.
      always_comb begin
        stab_d = stab_q;
        cnt_d  = cnt_q;
        if (sw_sync_q[i] == stab_q) begin
          cnt_d = '0;
        end else if (cnt_q == DEB_LAST) begin
          stab_d = sw_sync_q[i];
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_q + DEB_W'(1);
        end
      end

      // Debounce state register.
      always_ff @(posedge clk_25m or posedge rst_in) begin
        if (rst_in) begin
          stab_q <= 1'b1;
          cnt_q  <= '0;
        end else begin
          stab_q <= stab_d;
          cnt_q  <= cnt_d;
        end
      end

      assign stable_w[i] = stab_q;
    end
  endgenerate

  // Priority decode: lowest-index pressed switch wins.
  always_comb begin
    sel_d = 3'd0;
    if (!stable_w[0])      sel_d = 3'd1;
    else if (!stable_w[1]) sel_d = 3'd2;
    else if (!stable_w[2]) sel_d = 3'd3;
    else if (!stable_w[3]) sel_d = 3'd4;
  end

  generate
    for (genvar i = 0; i < 2; i++) begin : g_hlth
      logic [31:0] cnt_w;
      logic        in_rng_w;
      logic [1:0]  good_q, good_d;
      logic        ok_q, ok_d;
      logic        fault_q, fault_d;

      assign cnt_w    = (i == 0) ? mon_cnt0_i : mon_cnt1_i;
      assign in_rng_w = (i == 0) ? ((cnt_w >= CNT0_MIN) && (cnt_w <= CNT0_MAX))
                                 : ((cnt_w >= CNT1_MIN) && (cnt_w <= CNT1_MAX));

      // Qualify on each strobe; an out-of-range sample overrides a fault clear.
      always_comb begin
        good_d  = good_q;
        ok_d    = ok_q;
        fault_d = fault_q;
        if (clr_fault_i) fault_d = 1'b0;
        if (mon_vld_i) begin
          if (in_rng_w) begin
            good_d = (good_q == 2'd2) ? 2'd2 : good_q + 2'd1;
            if (good_d == 2'd2) ok_d = 1'b1;
          end else begin
            good_d  = 2'd0;
            ok_d    = 1'b0;
            fault_d = 1'b1;
          end
        end
      end

      // Clock-health state register.
      always_ff @(posedge clk_25m or posedge rst_in) begin
        if (rst_in) begin
          good_q  <= 2'd0;
          ok_q    <= 1'b0;
          fault_q <= 1'b0;
        end else begin
          good_q  <= good_d;
          ok_q    <= ok_d;
          fault_q <= fault_d;
        end
      end

      assign clk_ok_o[i]    = ok_q;
      assign clk_fault_o[i] = fault_q;
    end
  endgenerate

  // LED pattern chosen by the registered display select.
  always_comb begin
    led_d = 4'h0;
    case (sel_q)
      3'd0:    led_d = {clk_fault_o, clk_ok_o};
      3'd1:    led_d = hb_q[HB_MSB -: 4];
      3'd2:    led_d = {hb_q[HB_MSB], 1'b0, clk_ok_o};
      3'd3:    led_d = {hb_q[HB_MSB], 1'b0, clk_fault_o};
      3'd4:    led_d = 4'hF;
      default: led_d = 4'h0;
    endcase
  end

  // Select, heartbeat and LED output registers.
  always_ff @(posedge clk_25m or posedge rst_in) begin
    if (rst_in) begin
      sel_q <= 3'd0;
      hb_q  <= '0;
      led_q <= 4'h0;
    end else begin
      sel_q <= sel_d;
      hb_q  <= hb_q + HB_W'(1);
      led_q <= led_d;
    end
  end

  assign sel_o = sel_q;
  assign led_o = led_q;

endmodule
`default_nettype wire
